// File: rtl/analog_mux_seq_if.sv
// analog_mux_seq_if: command and mux-control bus for analog_mux_seq.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high. cmd_ch, cmd_scan and cmd_dwell must be stable
// whenever cmd_valid is high. cmd_ready is a registered output and does not
// depend combinationally on cmd_valid. stop and ena low override any
// command on the same edge, so no transfer happens on that edge.
interface analog_mux_seq_if #(
    parameter int N_CH    = 16,
    parameter int DWELL_W = 8
);
    logic               ena;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [3:0]         cmd_ch;
    logic               cmd_scan;
    logic [DWELL_W-1:0] cmd_dwell;
    logic               stop;
    logic [N_CH-1:0]    ctrl;
    logic [3:0]         sel_ch;
    logic               busy;
    logic               sample_strobe;

    // Command source side (sequencer owner / testbench)
    modport master (
        output ena, cmd_valid, cmd_ch, cmd_scan, cmd_dwell, stop,
        input  cmd_ready, ctrl, sel_ch, busy, sample_strobe
    );

    // Sequencer side
    modport slave (
        input  ena, cmd_valid, cmd_ch, cmd_scan, cmd_dwell, stop,
        output cmd_ready, ctrl, sel_ch, busy, sample_strobe
    );
endinterface

// File: rtl/analog_mux_seq.sv
// analog_mux_seq: break-before-make sequencer for a bank of analog_mux
// control lines. Each selection is preceded by DEAD_CYCLES all-off cycles,
// then one control line is held for the dwell time, with a sample strobe on
// the final dwell cycle. Single-select parks on the channel (HOLD);
// auto-scan steps to the next channel through another break.
//
// Optional feature: define ANALOG_MUX_SEQ_SCAN_EN to compile in auto-scan.
// Without it cmd_scan is ignored and every command is a single select.
//
// state_dbg exposes the FSM state: 0 IDLE, 1 BREAK, 2 DWELL, 3 HOLD.
module analog_mux_seq #(
    parameter int N_CH        = 16,
    parameter int DEAD_CYCLES = 2,
    parameter int DWELL_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    analog_mux_seq_if.slave   bus,
    output logic [1:0]        state_dbg
);
    // One counter serves both the break and the dwell phases.
    localparam int CNT_W = (DWELL_W > 4) ? DWELL_W : 4;
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [3:0]       CH_MAX    = 4'(N_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BREAK = 2'd1,
        S_DWELL = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [3:0]         sel_q, sel_d;
    logic [N_CH-1:0]    ctrl_q, ctrl_d;
    logic               busy_q, busy_d;
    logic               strobe_q, strobe_d;
    logic               ready_q, ready_d;
`ifdef ANALOG_MUX_SEQ_SCAN_EN
    logic               scan_q, scan_d;
    logic [3:0]         sel_next;
`else
    logic               unused_cmd_scan;
`endif

    logic               accept;
    logic [3:0]         ch_clamped;
    logic [CNT_W-1:0]   dwell_last;

    // A command is taken only when ready, enabled and not being aborted.
    assign accept     = bus.cmd_valid && ready_q && bus.ena && !bus.stop;
    assign ch_clamped = ({1'b0, bus.cmd_ch} >= 5'(N_CH)) ? CH_MAX : bus.cmd_ch;
    // Dwell of 0 behaves like 1, so the last count index is 0 in both cases.
    assign dwell_last = (dwell_q == '0) ? '0 : (CNT_W'(dwell_q) - CNT_W'(1));

`ifdef ANALOG_MUX_SEQ_SCAN_EN
    assign sel_next = (sel_q == CH_MAX) ? 4'd0 : (sel_q + 4'd1);
`else
    assign unused_cmd_scan = bus.cmd_scan;
`endif

    // Next-state and registered-output computation
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dwell_d  = dwell_q;
        sel_d    = sel_q;
        ctrl_d   = ctrl_q;
        busy_d   = busy_q;
        strobe_d = 1'b0;
`ifdef ANALOG_MUX_SEQ_SCAN_EN
        scan_d   = scan_q;
`endif
        if (!bus.ena || bus.stop) begin
            state_d = S_IDLE;
            ctrl_d  = '0;
            busy_d  = 1'b0;
`ifdef ANALOG_MUX_SEQ_SCAN_EN
            scan_d  = 1'b0;
`endif
        end else if (accept) begin
            // Every new selection, even of the same channel, breaks first.
            state_d = S_BREAK;
            sel_d   = ch_clamped;
            dwell_d = bus.cmd_dwell;
            cnt_d   = DEAD_LAST;
            ctrl_d  = '0;
            busy_d  = 1'b1;
`ifdef ANALOG_MUX_SEQ_SCAN_EN
            scan_d  = bus.cmd_scan;
`endif
        end else begin
            case (state_q)
                S_BREAK: begin
                    if (cnt_q == '0) begin
                        state_d  = S_DWELL;
                        ctrl_d   = N_CH'(1) << sel_q;
                        cnt_d    = dwell_last;
                        strobe_d = (dwell_last == '0);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_DWELL: begin
                    if (cnt_q != '0) begin
                        cnt_d    = cnt_q - CNT_W'(1);
                        strobe_d = (cnt_q == CNT_W'(1));
                    end else begin
                        state_d = S_HOLD;
                        busy_d  = 1'b0;
`ifdef ANALOG_MUX_SEQ_SCAN_EN
                        if (scan_q) begin
                            state_d = S_BREAK;
                            busy_d  = 1'b1;
                            ctrl_d  = '0;
                            sel_d   = sel_next;
                            cnt_d   = DEAD_LAST;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
        ready_d = bus.ena && ((state_d == S_IDLE) || (state_d == S_HOLD));
    end

    // State and output registers, cleared asynchronously by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            dwell_q  <= '0;
            sel_q    <= '0;
            ctrl_q   <= '0;
            busy_q   <= 1'b0;
            strobe_q <= 1'b0;
            ready_q  <= 1'b0;
`ifdef ANALOG_MUX_SEQ_SCAN_EN
            scan_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dwell_q  <= dwell_d;
            sel_q    <= sel_d;
            ctrl_q   <= ctrl_d;
            busy_q   <= busy_d;
            strobe_q <= strobe_d;
            ready_q  <= ready_d;
`ifdef ANALOG_MUX_SEQ_SCAN_EN
            scan_q   <= scan_d;
`endif
        end
    end

    assign bus.ctrl          = ctrl_q;
    assign bus.sel_ch        = sel_q;
    assign bus.busy          = busy_q;
    assign bus.sample_strobe = strobe_q;
    assign bus.cmd_ready     = ready_q;
    assign state_dbg         = state_q;
endmodule

// File: tb/tb_analog_mux_seq.sv
// tb_analog_mux_seq: bench for analog_mux_seq. A queue-based reference model
// expands each accepted command into its expected per-cycle ctrl/strobe/busy
// trace; directed vectors, corner-case sequences and a random soak run
// against it. A second small instance (N_CH=10) covers channel clamping.
// Builds with or without ANALOG_MUX_SEQ_SCAN_EN.
module tb_analog_mux_seq;
    localparam int N_CH = 16;
    localparam int DEAD = 2;
    localparam int DW   = 8;
    localparam int EW   = N_CH + 6;   // {busy, strobe, sel[3:0], ctrl}
`ifdef ANALOG_MUX_SEQ_SCAN_EN
    localparam bit SCAN_EN = 1'b1;
`else
    localparam bit SCAN_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0] state_dbg, state_dbg_c;
    analog_mux_seq_if #(.N_CH(N_CH), .DWELL_W(DW)) bus ();
    analog_mux_seq_if #(.N_CH(10), .DWELL_W(DW)) bus_c ();

    analog_mux_seq #(.N_CH(N_CH), .DEAD_CYCLES(DEAD), .DWELL_W(DW)) dut (
        .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg)
    );
    analog_mux_seq #(.N_CH(10), .DEAD_CYCLES(1), .DWELL_W(DW)) dut_c (
        .clk(clk), .rst(rst), .bus(bus_c), .state_dbg(state_dbg_c)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [EW-1:0]   exp_q[$];
    logic [N_CH-1:0] m_ctrl, m_hold;
    logic [3:0]      m_sel;
    logic            m_strobe, m_busy, m_ready, m_scan;
    int              m_ch, m_dw;

    function automatic logic [N_CH-1:0] onehot(input int c);
        logic [N_CH-1:0] v;
        v = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    // One channel visit: DEAD all-off cycles then d cycles on, strobe on the last.
    task automatic push_seg(input int c, input int d);
        for (int i = 0; i < DEAD; i++)
            exp_q.push_back({1'b1, 1'b0, 4'(c), {N_CH{1'b0}}});
        for (int i = 0; i < d; i++)
            exp_q.push_back({1'b1, (i == d - 1), 4'(c), onehot(c)});
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_ctrl = '0; m_hold = '0; m_sel = '0;
            m_strobe = 1'b0; m_busy = 1'b0; m_ready = 1'b0; m_scan = 1'b0;
            m_ch = 0; m_dw = 1;
        end else begin
            logic [EW-1:0] e;
            if (!bus.ena || bus.stop) begin
                exp_q.delete();
                m_scan = 1'b0;
                m_hold = '0;
                e = {1'b0, 1'b0, m_sel, {N_CH{1'b0}}};
            end else begin
                if (bus.cmd_valid && m_ready) begin
                    exp_q.delete();
                    m_ch   = (bus.cmd_ch >= N_CH) ? N_CH - 1 : int'(bus.cmd_ch);
                    m_dw   = (bus.cmd_dwell == 0) ? 1 : int'(bus.cmd_dwell);
                    m_scan = SCAN_EN && bus.cmd_scan;
                    m_hold = onehot(m_ch);
                    push_seg(m_ch, m_dw);
                end
                if (exp_q.size() == 0 && m_scan) begin
                    m_ch   = (m_ch + 1) % N_CH;
                    m_hold = onehot(m_ch);
                    push_seg(m_ch, m_dw);
                end
                if (exp_q.size() != 0) e = exp_q.pop_front();
                else                   e = {1'b0, 1'b0, 4'(m_ch), m_hold};
            end
            {m_busy, m_strobe, m_sel, m_ctrl} = e;
            m_ready = bus.ena && !m_busy;
        end
    end

    // ---------------- scoreboard compare (negedge) ----------------
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("sb_ctrl", bus.ctrl, m_ctrl);
            chk("sb_strobe", bus.sample_strobe, m_strobe);
            chk("sb_busy", bus.busy, m_busy);
            chk("sb_ready", bus.cmd_ready, m_ready);
            if (m_ctrl != '0) chk("sb_sel", bus.sel_ch, m_sel);
        end
    end

    // One-hot and dead-time invariant
    logic [N_CH-1:0] last_nz = '0;
    int zero_run = 1000;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("inv_onehot", ($countones(bus.ctrl) <= 1), 1);
            if (bus.ctrl == '0) zero_run++;
            else begin
                if (last_nz != '0 && bus.ctrl != last_nz)
                    chk("inv_dead_time", (zero_run >= DEAD), 1);
                last_nz  = bus.ctrl;
                zero_run = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input int ch, input bit scan, input int dw);
        int n;
        n = 0;
        while (!bus.cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_ch    = 4'(ch);
        bus.cmd_scan  = scan;
        bus.cmd_dwell = DW'(dw);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic do_stop();
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        chk("stop_ctrl_off", bus.ctrl, 0);
    endtask

    typedef struct {
        int              ch;
        int              dwell;
        logic [N_CH-1:0] exp_ctrl;
        int              exp_len;
    } vec_t;
    vec_t vecs[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1);
    end

    // ---------------- main test ----------------
    initial begin
        logic [N_CH-1:0] scan_exp[10];
        vecs[0] = '{3, 4, 16'h0008, 4};
        vecs[1] = '{15, 0, 16'h8000, 1};
        vecs[2] = '{0, 1, 16'h0001, 1};
        vecs[3] = '{7, 3, 16'h0080, 3};
        vecs[4] = '{9, 2, 16'h0200, 2};

        bus.ena = 1'b0; bus.cmd_valid = 1'b0; bus.cmd_ch = '0;
        bus.cmd_scan = 1'b0; bus.cmd_dwell = '0; bus.stop = 1'b0;
        bus_c.ena = 1'b0; bus_c.cmd_valid = 1'b0; bus_c.cmd_ch = '0;
        bus_c.cmd_scan = 1'b0; bus_c.cmd_dwell = '0; bus_c.stop = 1'b0;

        // Reset state while rst is held
        #2;
        chk("rst_ctrl", bus.ctrl, 0);
        chk("rst_sel", bus.sel_ch, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_strobe", bus.sample_strobe, 0);
        chk("rst_ready", bus.cmd_ready, 0);
        repeat (2) @(negedge clk);
        bus.ena = 1'b1;
        bus_c.ena = 1'b1;
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", bus.cmd_ready, 1);

        // Directed single-select vectors from IDLE
        foreach (vecs[k]) begin
            send_cmd(vecs[k].ch, 1'b0, vecs[k].dwell);
            for (int i = 0; i < DEAD; i++) begin
                chk("vec_break_off", bus.ctrl, 0);
                @(negedge clk);
            end
            for (int i = 0; i < vecs[k].exp_len; i++) begin
                chk("vec_dwell_ctrl", bus.ctrl, vecs[k].exp_ctrl);
                chk("vec_strobe", bus.sample_strobe, (i == vecs[k].exp_len - 1));
                @(negedge clk);
            end
            chk("vec_hold_ctrl", bus.ctrl, vecs[k].exp_ctrl);
            chk("vec_hold_ready", bus.cmd_ready, 1);
            chk("vec_hold_busy", bus.busy, 0);
            do_stop();
        end

        // Clamp: ch 12 on a 10-channel instance, dwell 0, one break cycle
        bus_c.cmd_valid = 1'b1; bus_c.cmd_ch = 4'd12; bus_c.cmd_dwell = '0;
        @(negedge clk);
        bus_c.cmd_valid = 1'b0;
        chk("clamp_break", bus_c.ctrl, 0);
        @(negedge clk);
        chk("clamp_ctrl", bus_c.ctrl, 10'h200);
        chk("clamp_strobe", bus_c.sample_strobe, 1);
        chk("clamp_sel", bus_c.sel_ch, 9);
        @(negedge clk);
        chk("clamp_hold", bus_c.ctrl, 10'h200);
        chk("clamp_hold_strobe", bus_c.sample_strobe, 0);

        // Stop and cmd_valid together during DWELL
        send_cmd(5, 1'b0, 10);
        repeat (DEAD + 2) @(negedge clk);
        chk("stopcmd_in_dwell", bus.ctrl, 16'h0020);
        bus.stop = 1'b1; bus.cmd_valid = 1'b1; bus.cmd_ch = 4'd6; bus.cmd_dwell = 8'd1;
        @(negedge clk);
        bus.stop = 1'b0; bus.cmd_valid = 1'b0;
        chk("stopcmd_ctrl", bus.ctrl, 0);
        chk("stopcmd_busy", bus.busy, 0);
        chk("stopcmd_idle_ready", bus.cmd_ready, 1);
        repeat (DEAD + 2) begin
            @(negedge clk);
            chk("stopcmd_not_taken", bus.ctrl, 0);
        end

        // Re-select the same channel from HOLD: must break first
        send_cmd(4, 1'b0, 2);
        repeat (DEAD + 2) @(negedge clk);
        chk("resel_hold", bus.ctrl, 16'h0010);
        send_cmd(4, 1'b0, 2);
        chk("resel_break", bus.ctrl, 0);
        chk("resel_busy", bus.busy, 1);
        repeat (DEAD) @(negedge clk);
        chk("resel_dwell", bus.ctrl, 16'h0010);
        do_stop();

        // ena low behaves as stop and ignores commands
        send_cmd(6, 1'b0, 1);
        repeat (DEAD + 1) @(negedge clk);
        chk("ena_hold", bus.ctrl, 16'h0040);
        bus.ena = 1'b0; bus.cmd_valid = 1'b1; bus.cmd_ch = 4'd2; bus.cmd_dwell = 8'd1;
        @(negedge clk);
        chk("ena_off_ctrl", bus.ctrl, 0);
        chk("ena_off_ready", bus.cmd_ready, 0);
        repeat (3) begin
            @(negedge clk);
            chk("ena_off_ignored", bus.ctrl, 0);
        end
        bus.ena = 1'b1; bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("ena_on_ready", bus.cmd_ready, 1);

        // Asynchronous reset between edges during DWELL
        send_cmd(2, 1'b0, 8);
        repeat (DEAD + 1) @(negedge clk);
        chk("arst_dwell", bus.ctrl, 16'h0004);
        #2 rst = 1'b1;
        #1;
        chk("arst_ctrl", bus.ctrl, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_ready", bus.cmd_ready, 0);
        chk("arst_sel", bus.sel_ch, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst_ready_back", bus.cmd_ready, 1);

`ifdef ANALOG_MUX_SEQ_SCAN_EN
        // Auto-scan wrap from 14
        scan_exp = '{16'h4000, 0, 0, 16'h8000, 0, 0, 16'h0001, 0, 0, 16'h0002};
        send_cmd(14, 1'b1, 1);
        repeat (DEAD) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk("scan_ctrl", bus.ctrl, scan_exp[i]);
            chk("scan_strobe", bus.sample_strobe, (scan_exp[i] != 0));
            chk("scan_ready", bus.cmd_ready, 0);
            @(negedge clk);
        end
        do_stop();
`else
        // Without scan support, scan=1 is a single select that never advances
        scan_exp[0] = 16'h0020;
        send_cmd(5, 1'b1, 3);
        repeat (DEAD + 3) @(negedge clk);
        repeat (100) begin
            chk("noscan_hold", bus.ctrl, scan_exp[0]);
            @(negedge clk);
        end
        chk("noscan_sel", bus.sel_ch, 5);
        do_stop();
`endif

        // Random soak against the model
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            bus.stop      = (r < 2);
            bus.ena       = !(r >= 2 && r < 4);
            bus.cmd_valid = ($urandom_range(0, 7) == 0);
            bus.cmd_ch    = 4'($urandom_range(0, 15));
            bus.cmd_scan  = 1'($urandom_range(0, 1));
            bus.cmd_dwell = DW'($urandom_range(0, 4));
            @(negedge clk);
        end
        bus.stop = 1'b0; bus.ena = 1'b1; bus.cmd_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
